// File: rtl/window_counter_pkg.sv
// Shared types and default widths for the window_counter measurement block.
package window_counter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 32;
  localparam int WIN_W_DEF = 16;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = '1;
  localparam logic [WIN_W_DEF-1:0] WIN_MAX_DEF = '1;

endpackage

// File: rtl/edge_sync.sv
// Rising-edge detector on the event line, with an optional two-flop
// synchroniser in front of it when WINDOW_COUNTER_SYNC_EN is defined.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic ev_s;
  logic ev_d_reg;

`ifdef WINDOW_COUNTER_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (reset) sync_reg <= '0;
    else       sync_reg <= {sync_reg[0], d};
  end

  assign ev_s = sync_reg[1];
`else
  assign ev_s = d;
`endif

  always_ff @(posedge clk) begin
    if (reset) ev_d_reg <= 1'b0;
    else       ev_d_reg <= ev_s;
  end

  assign rise = ev_s & ~ev_d_reg;

endmodule

// File: rtl/window_counter.sv
// Counts event rising edges while start is high and hands the per-window
// result to a valid/ready reader. Optional input sync: WINDOW_COUNTER_SYNC_EN.
module window_counter
  import window_counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             event_in,
  input  logic             result_ready,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_count,
  output logic [WIN_W-1:0] result_cycles,
  output logic             overflow,
  output logic             dropped,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] WIN_MAX = '1;

  state_t           state_reg;
  logic [CNT_W-1:0] edge_cnt_reg;
  logic [WIN_W-1:0] win_cnt_reg;
  logic             rise;
  logic             commit;

  edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .d     (event_in),
    .rise  (rise)
  );

  assign commit = (state_reg == COUNT) && !start;
  assign busy   = (state_reg == COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      edge_cnt_reg  <= '0;
      win_cnt_reg   <= '0;
      result_valid  <= 1'b0;
      result_count  <= '0;
      result_cycles <= '0;
      overflow      <= 1'b0;
      dropped       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= COUNT;
            edge_cnt_reg <= rise ? CNT_W'(1) : '0;
            win_cnt_reg  <= WIN_W'(1);
          end
        end
        COUNT: begin
          if (start) begin
            if (win_cnt_reg != WIN_MAX) win_cnt_reg <= win_cnt_reg + WIN_W'(1);
            if (rise) begin
              if (edge_cnt_reg == CNT_MAX) overflow <= 1'b1;
              else                         edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // A commit wins over a transfer; a same-cycle transfer saves it from being a drop.
      if (commit) begin
        result_count  <= edge_cnt_reg;
        result_cycles <= win_cnt_reg;
        result_valid  <= 1'b1;
        if (result_valid && !result_ready) dropped <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_counter.sv
// Self-checking bench: two window_counter instances (default widths and a
// narrow 4/5-bit build) driven in lock-step and checked against a window model.
module tb_window_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic event_in = 1'b0;
  logic result_ready = 1'b0;

  logic        rv_a, ov_a, dr_a, busy_a;
  logic [31:0] rc_a;
  logic [15:0] ry_a;
  logic        rv_b, ov_b, dr_b, busy_b;
  logic [3:0]  rc_b;
  logic [4:0]  ry_b;

  always #5 clk = ~clk;

  window_counter dut_a (
    .clk(clk), .reset(reset), .start(start), .event_in(event_in),
    .result_ready(result_ready), .result_valid(rv_a), .result_count(rc_a),
    .result_cycles(ry_a), .overflow(ov_a), .dropped(dr_a), .busy(busy_a)
  );

  window_counter #(.CNT_W(4), .WIN_W(5)) dut_b (
    .clk(clk), .reset(reset), .start(start), .event_in(event_in),
    .result_ready(result_ready), .result_valid(rv_b), .result_count(rc_b),
    .result_cycles(ry_b), .overflow(ov_b), .dropped(dr_b), .busy(busy_b)
  );

`ifdef WINDOW_COUNTER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a window is a run of start=1 samples; its result is the
  // number of rising edges seen (delayed by the sync stages) and its length.
  logic [3:0] ev_h = '0;
  bit         in_win = 1'b0;
  longint     w_edges = 0, w_len = 0;
  longint     cmax [2] = '{64'hFFFF_FFFF, 15};
  longint     wmax [2] = '{65535, 31};
  longint     m_count [2] = '{0, 0};
  longint     m_cycles [2] = '{0, 0};
  bit         m_ovf [2] = '{1'b0, 1'b0};
  bit         m_valid = 1'b0;
  bit         m_drop = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit ev, input bit rdy);
    bit rise_m;
    if (rst) begin
      ev_h = '0; in_win = 1'b0; w_edges = 0; w_len = 0;
      m_valid = 1'b0; m_drop = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_count[i] = 0; m_cycles[i] = 0; m_ovf[i] = 1'b0;
      end
      return;
    end
    ev_h = {ev_h[2:0], ev};
    rise_m = ev_h[LAT] & ~ev_h[LAT+1];
    if (st) begin
      if (!in_win) begin
        in_win = 1'b1; w_edges = 0; w_len = 0;
      end
      w_len++;
      if (rise_m) w_edges++;
      for (int i = 0; i < 2; i++) if (w_edges > cmax[i]) m_ovf[i] = 1'b1;
    end
    if (!st && in_win) begin
      in_win = 1'b0;
      if (m_valid && !rdy) m_drop = 1'b1;
      m_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_count[i]  = (w_edges > cmax[i]) ? cmax[i] : w_edges;
        m_cycles[i] = (w_len > wmax[i]) ? wmax[i] : w_len;
      end
      $display("[TB] window closed: %0d edges over %0d cycles", w_edges, w_len);
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("a.valid",   rv_a,   m_valid);
    chk("a.count",   rc_a,   m_count[0]);
    chk("a.cycles",  ry_a,   m_cycles[0]);
    chk("a.ovf",     ov_a,   m_ovf[0]);
    chk("a.dropped", dr_a,   m_drop);
    chk("a.busy",    busy_a, in_win);
    chk("b.valid",   rv_b,   m_valid);
    chk("b.count",   rc_b,   m_count[1]);
    chk("b.cycles",  ry_b,   m_cycles[1]);
    chk("b.ovf",     ov_b,   m_ovf[1]);
    chk("b.dropped", dr_b,   m_drop);
    chk("b.busy",    busy_b, in_win);
  endtask

  task automatic cycle(input bit rst, input bit st, input bit ev, input bit rdy);
    reset = rst; start = st; event_in = ev; result_ready = rdy;
    @(posedge clk);
    #1;
    model_step(rst, st, ev, rdy);
    compare_all();
  endtask

  // Window of len cycles with n single-cycle pulses at even offsets, then the closing cycle.
  task automatic run_win(input int len, input int n, input bit rdy_at_close);
    for (int i = 0; i < len; i++) cycle(1'b0, 1'b1, (i % 2 == 0) && (i / 2 < n), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, rdy_at_close);
  endtask

  initial begin
    bit st_r, ev_r, rdy_r, rst_r;

    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.valid", rv_a, 0);
    chk("reset.busy", busy_a, 0);

    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, (i == 2 || i == 4 || i == 6), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("w1.valid", rv_a, 1);
    chk("w1.count", rc_a, 3);
    chk("w1.cycles", ry_a, 10);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("w1.drain", rv_a, 0);

    run_win(5, 1, 1'b0);
    run_win(7, 2, 1'b0);
    chk("drop.flag", dr_a, 1);
    chk("drop.count", rc_a, 2);
    chk("drop.cycles", ry_a, 7);

    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_win(5, 1, 1'b0);
    run_win(7, 2, 1'b1);
    chk("xfer.dropped", dr_a, 0);
    chk("xfer.valid", rv_a, 1);
    chk("xfer.count", rc_a, 2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    run_win(44, 20, 1'b1);
    chk("ovf.b_count", rc_b, 15);
    chk("ovf.b_flag", ov_b, 1);
    chk("ovf.b_cycles", ry_b, 31);
    chk("ovf.a_count", rc_a, 20);
    chk("ovf.a_flag", ov_a, 0);
    run_win(5, 1, 1'b1);
    chk("ovf.sticky", ov_b, 1);
    chk("ovf.next_count", rc_b, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf.cleared", ov_b, 0);

    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, (i % 2 == 1), 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort.valid", rv_a, 0);
    run_win(8, 2, 1'b0);
    chk("abort.count", rc_a, 2);
    chk("abort.cycles", ry_a, 8);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, (i == 4), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("late_edge.count", rc_a, (LAT == 0) ? 1 : 0);

    st_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst_r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, st_r ? 19 : 3) == 0) st_r = !st_r;
      ev_r  = 1'($urandom_range(0, 1));
      rdy_r = ($urandom_range(0, 2) == 0);
      cycle(rst_r, st_r, ev_r, rdy_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/window_counter.md
# window_counter

Measurement-side companion to the run sequencer. It consumes the sequencer's `reset` and `start` strobes and counts rising edges of a sensor/event line while `start` is high. When the window closes it latches the edge count and the window length into a result register, which a downstream reader drains over a valid/ready handshake. It sits between the sequencer and the readout/UART path.

## Interface
- `CNT_W`, 32, width of the edge counter and the `result_count` port.
- `WIN_W`, 16, width of the window-length counter; matches the sequencer `Duration` width.
- `clk  input  1  system clock; all logic on posedge`
- `reset  input  1  synchronous, active-high; driven directly by the sequencer reset output`
- `start  input  1  measurement window; high = count`
- `event_in  input  1  event/sensor line`
- `result_ready  input  1  reader accepts the result`
- `result_valid  output  1  result registers hold an unread window`
- `result_count  output  CNT_W  rising edges counted in the window`
- `result_cycles  output  WIN_W  cycles during which start was high`
- `overflow  output  1  sticky; the edge counter saturated in some window`
- `dropped  output  1  sticky; an unread result was overwritten`
- `busy  output  1  a window is in progress (state COUNT)`

## Operation
- Reset is synchronous and active-high. While `reset`=1, at each clock edge the block sets:
  - state to IDLE;
  - the working counters and edge-detect history to 0;
  - `result_valid`, `result_count`, `result_cycles`, `overflow`, `dropped` and `busy` to 0.
- An unread result is lost when the sequencer begins a new run. The reader must drain it before the next run.
- State machine, two states:
  - IDLE: if `start`=1, go to COUNT. Load `edge_cnt` = edge ? 1 : 0 and `win_cnt` = 1.
  - COUNT with `start`=1: increment `win_cnt`, saturating at 2^WIN_W−1. If edge is set, increment `edge_cnt`.
  - COUNT with `start`=0: return to IDLE and commit the result. This cycle is not counted.
- Edge definition: edge = ev_s & ~ev_d. `ev_s` is the (optionally synchronised) event sample and `ev_d` is its one-cycle delay. An edge is counted only in a cycle where `start`=1.
- Edge-counter saturation: `edge_cnt` holds at 2^CNT_W−1. The first increment attempted at that maximum sets `overflow`, which stays set until reset.
- Commit:
  - `result_count` ← `edge_cnt` and `result_cycles` ← `win_cnt`.
  - `result_valid` is 1 on the next cycle.
  - If `result_valid`=1 and `result_ready`=0 in the commit cycle, the old result is overwritten and `dropped` is set (sticky).
- Handshake:
  - A transfer occurs on a clock edge where `result_valid`=1 and `result_ready`=1.
  - `result_valid` drops the following cycle, unless a commit happens in the same cycle.
  - Commit and transfer in the same cycle: the new result loads, `result_valid` stays 1, and `dropped` is not set.
  - Result outputs stay stable while `result_valid`=1 and no commit occurs.
- `result_ready` with `result_valid`=0 has no effect.
- A window can start while a previous result is pending. Working counters are separate from the result registers.

## Timing
- Commit latency: the result is visible the cycle after the first `start`=0 sample.
- A window with `start` high for N cycles gives `result_cycles`=N. With the sequencer this is Duration+1.
- A one-cycle `start` pulse gives `result_cycles`=1, and `result_count` equal to the edge in that cycle (0 or 1).
- Edge-to-count latency:
  - without the synchroniser, 1 cycle;
  - with it, 3 cycles (2 synchroniser stages plus the delay stage).
- Edges in the last latency cycles before the window closes are not counted.
- `busy` is the registered state: high from the cycle after `start` is first seen until the cycle after `start` falls.

## Configuration
- `WINDOW_COUNTER_SYNC_EN` defined: `event_in` passes through a two-flop synchroniser (reset to 0) before edge detection. This is for async sensor or ring-oscillator sources.
- Not defined: `event_in` is sampled directly and must be synchronous to `clk`. Edge latency is 1 cycle.

## Structure
- Shared package `window_counter_pkg` holds:
  - the state enum (IDLE=1'b0, COUNT=1'b1);
  - default widths CNT_W_DEF=32 and WIN_W_DEF=16;
  - saturation-max helper constants.
- One sub-module, `edge_sync`:
  - contains the optional synchroniser and the rising-edge detector;
  - ports: `clk`, `reset`, `d`, `rise`;
  - the macro is checked only inside this sub-module.

## Test plan
- `reset` for 4 cycles, then 0 → every output is 0; `busy`=0.
- `start` high 10 cycles, 3 clean event pulses mid-window, `result_ready`=0 → `result_valid`=1 one cycle after `start` falls, with `result_count`=3 and `result_cycles`=10. Hold `result_ready`=1 for one cycle → `result_valid`=0 next cycle.
- Second window completes with the prior result unread → new values loaded and `dropped`=1. Repeat with `result_ready`=1 in the commit cycle → `dropped`=0 and `result_valid` stays 1.
- Run with CNT_W=4 and 20 edges in a window → `result_count`=15 and `overflow`=1, which persists through later windows until `reset`.
- Assert `reset` mid-window after 5 edges → no result is produced. A following 8-cycle window with 2 edges gives `result_count`=2 and `result_cycles`=8.
- With `WINDOW_COUNTER_SYNC_EN`, an edge 2 cycles before `start` falls is not counted; without the macro the same stimulus counts it.
